// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the three requester ports (fetch, data,
// loader), the single-port RAM port and the busy flag.
// slave  : the arbiter's view (drives all o_* signals)
// master : the surrounding system's view (drives all i_* signals)
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12
);
    // instruction fetch (read-only)
    logic              i_f_req;
    logic [ADDR_W-1:0] i_f_addr;
    logic              o_f_ack;
    logic [DATA_W-1:0] o_f_rdata;
    logic              o_f_err;

    // cpu data (read/write)
    logic              i_d_req;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    logic              o_d_ack;
    logic [DATA_W-1:0] o_d_rdata;
    logic              o_d_err;

    // boot loader (write-only)
    logic              i_l_req;
    logic [ADDR_W-1:0] i_l_addr;
    logic [DATA_W-1:0] i_l_wdata;
    logic              o_l_ack;
    logic              o_l_err;

    // RAM port
    logic              o_mem_en;
    logic              o_mem_we;
    logic [MEM_AW-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    logic              o_busy;

    modport slave (
        input  i_f_req, i_f_addr,
        output o_f_ack, o_f_rdata, o_f_err,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
        output o_d_ack, o_d_rdata, o_d_err,
        input  i_l_req, i_l_addr, i_l_wdata,
        output o_l_ack, o_l_err,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_busy
    );

    modport master (
        output i_f_req, i_f_addr,
        input  o_f_ack, o_f_rdata, o_f_err,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata,
        input  o_d_ack, o_d_rdata, o_d_err,
        output i_l_req, i_l_addr, i_l_wdata,
        input  o_l_ack, o_l_err,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word RAM between CPU
// fetch (F), CPU data (D) and the boot loader (L). One access in flight,
// four-cycle slot IDLE -> ISSUE -> WAIT -> RESP, all outputs registered.
// Loader has absolute priority; F and D alternate round-robin.
// Optional feature: define MEM_ARB_RANGE_CHECK_EN to flag accesses with
// address bits above MEM_AW+1 set (no RAM strobe, err with ack, reads
// return 32'hDEADBEEF). Without it, err outputs stay 0 and addresses wrap.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12
) (
    input  logic          clk,
    input  logic          i_reset,
    mem_arbiter_if.slave  bus
);

`ifdef MEM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SRC_F, SRC_D, SRC_L} src_t;

    state_t state;
    src_t   owner;      // requester that owns the slot in flight
    src_t   rr_pref;    // preferred requester when F and D collide
    logic   own_we;
    logic   own_oor;

    src_t              grant;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_oor;
    logic              unused_addr_bits;

    // Pick the winner among live requests and mux its access fields.
    always_comb begin
        grant_any = bus.i_l_req | bus.i_f_req | bus.i_d_req;
        if (bus.i_l_req)
            grant = SRC_L;
        else if (bus.i_f_req && bus.i_d_req)
            grant = rr_pref;
        else if (bus.i_d_req)
            grant = SRC_D;
        else
            grant = SRC_F;

        sel_addr  = bus.i_f_addr;
        sel_wdata = '0;
        sel_we    = 1'b0;
        case (grant)
            SRC_L: begin
                sel_addr  = bus.i_l_addr;
                sel_wdata = bus.i_l_wdata;
                sel_we    = 1'b1;
            end
            SRC_D: begin
                sel_addr  = bus.i_d_addr;
                sel_wdata = bus.i_d_wdata;
                sel_we    = bus.i_d_we;
            end
            default: ;
        endcase
    end

    // Upper address bits only matter when range checking is built in.
    assign sel_oor          = RANGE_CHECK && (|sel_addr[ADDR_W-1:MEM_AW+2]);
    assign unused_addr_bits = ^sel_addr[1:0];

    // Slot sequencer: every output is a register written from here.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state           <= IDLE;
            owner           <= SRC_F;
            rr_pref         <= SRC_F;
            own_we          <= 1'b0;
            own_oor         <= 1'b0;
            bus.o_f_ack     <= 1'b0;
            bus.o_d_ack     <= 1'b0;
            bus.o_l_ack     <= 1'b0;
            bus.o_f_err     <= 1'b0;
            bus.o_d_err     <= 1'b0;
            bus.o_l_err     <= 1'b0;
            bus.o_f_rdata   <= '0;
            bus.o_d_rdata   <= '0;
            bus.o_mem_en    <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= '0;
            bus.o_mem_wdata <= '0;
            bus.o_busy      <= 1'b0;
        end else begin
            bus.o_f_ack  <= 1'b0;
            bus.o_d_ack  <= 1'b0;
            bus.o_l_ack  <= 1'b0;
            bus.o_f_err  <= 1'b0;
            bus.o_d_err  <= 1'b0;
            bus.o_l_err  <= 1'b0;
            bus.o_mem_en <= 1'b0;
            bus.o_mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner           <= grant;
                        own_we          <= sel_we;
                        own_oor         <= sel_oor;
                        bus.o_mem_addr  <= sel_addr[MEM_AW+1:2];
                        bus.o_mem_wdata <= sel_wdata;
                        bus.o_mem_en    <= !sel_oor;
                        bus.o_mem_we    <= sel_we && !sel_oor;
                        bus.o_busy      <= 1'b1;
                        state           <= ISSUE;
                        if (grant == SRC_F)
                            rr_pref <= SRC_D;
                        else if (grant == SRC_D)
                            rr_pref <= SRC_F;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!own_we) begin
                        if (owner == SRC_F)
                            bus.o_f_rdata <= own_oor ? DATA_W'(32'hDEADBEEF) : bus.i_mem_rdata;
                        else if (owner == SRC_D)
                            bus.o_d_rdata <= own_oor ? DATA_W'(32'hDEADBEEF) : bus.i_mem_rdata;
                    end
                    bus.o_f_ack <= (owner == SRC_F);
                    bus.o_d_ack <= (owner == SRC_D);
                    bus.o_l_ack <= (owner == SRC_L);
                    bus.o_f_err <= (owner == SRC_F) && own_oor;
                    bus.o_d_err <= (owner == SRC_D) && own_oor;
                    bus.o_l_err <= (owner == SRC_L) && own_oor;
                    state       <= RESP;
                end
                RESP: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous word RAM between three requesters: CPU instruction fetch (F, read-only), CPU data (D, read/write) and the boot loader (L, write-only, fed from the UART loader).
- Sits between the cpu core's fetch and data ports and the memory.
- One access in flight at a time, all outputs registered.
- Arbitration: loader has absolute priority; fetch and data share the remaining slots round-robin.

Parameters:
- ADDR_W, 32, byte-address width of the requester ports
- DATA_W, 32, data word width
- MEM_AW, 12, word-address width of the RAM (RAM holds 2^MEM_AW words)

Ports:
- clk  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- i_f_req  in  1  fetch request; held high until o_f_ack
- i_f_addr  in  ADDR_W  fetch byte address
- o_f_ack  out  1  one-cycle completion pulse
- o_f_rdata  out  DATA_W  fetched word; valid while o_f_ack is high and held until the next F read
- i_d_req  in  1  data request; held high until o_d_ack
- i_d_we  in  1  1 = write, 0 = read
- i_d_addr  in  ADDR_W  data byte address
- i_d_wdata  in  DATA_W  write data
- o_d_ack  out  1  completion pulse
- o_d_rdata  out  DATA_W  read data
- i_l_req  in  1  loader write request
- i_l_addr  in  ADDR_W  loader byte address
- i_l_wdata  in  DATA_W  loader write data
- o_l_ack  out  1  completion pulse
- o_f_err / o_d_err / o_l_err  out  1 each  error flag, qualified by the matching ack (see Optional Feature)
- o_mem_en  out  1  RAM access strobe
- o_mem_we  out  1  RAM write enable
- o_mem_addr  out  MEM_AW  RAM word address
- o_mem_wdata  out  DATA_W  RAM write data
- i_mem_rdata  in  DATA_W  RAM read data, valid the cycle after o_mem_en
- o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: FSM = IDLE; all acks, errs, o_mem_en, o_mem_we and o_busy = 0; o_mem_addr, o_mem_wdata, o_f_rdata and o_d_rdata = 0; round-robin pointer = F.
- FSM states:
  - IDLE: sample the requests. If any is high, latch the winner's id, we, addr and wdata, and go to ISSUE.
  - ISSUE: o_mem_en = 1; o_mem_we = 1 for D writes and for all L accesses; go to WAIT.
  - WAIT: on a read, register i_mem_rdata into the winner's rdata; go to RESP.
  - RESP: pulse the winner's ack for exactly one cycle; go to IDLE.
- Latency: a request seen high in IDLE at cycle N is acked at cycle N+3. Peak throughput is one access per 4 cycles (IDLE, ISSUE, WAIT, RESP).
- Handshake:
  - The requester holds req, addr and wdata stable until it samples ack, then drops req.
  - If req is still high in the IDLE cycle after RESP, it is treated as a new request.
  - Changing addr or wdata after grant has no effect on the access in flight.
- Arbitration:
  - L beats F and D.
  - Between F and D, the pointer names the preferred requester. After an F grant the pointer moves to D; after a D grant it moves to F.
  - L grants leave the pointer unchanged.
  - If only one requester is high, it wins regardless of the pointer.
- Address mapping: o_mem_addr = addr[MEM_AW+1:2]. Bits [1:0] are ignored; all accesses are full-word.
- On D writes, o_d_rdata is not updated.
- Reset mid-operation: the access is abandoned, no ack is issued, and outputs return to reset values. A requester still holding req is re-arbitrated after reset.
- Simultaneous L, F and D requests: grant order is L, then F/D per the pointer, then the remaining one, each separated by a full 4-cycle slot.

Optional Feature:
- Macro: MEM_ARB_RANGE_CHECK_EN.
- When defined: an access with any address bit above MEM_AW+1 set is out of range.
  - The FSM still walks ISSUE, WAIT and RESP, but o_mem_en stays 0.
  - The winner's err is asserted together with its ack.
  - Read data for an out-of-range read is 32'hDEADBEEF.
- When undefined: all err outputs are tied to 0 and upper address bits are silently ignored, so the address wraps modulo 2^MEM_AW words.

Test Plan:
- F read of 0x10, RAM word 4 = 0xE3A01041 -> o_mem_en at cycle 1 with o_mem_addr = 4; o_f_ack at cycle 3 with o_f_rdata = 0xE3A01041.
- D write 0x55AA to 0x20, then D read of 0x20 -> o_mem_we = 1 with addr 8 on the write; the read returns 0x55AA; o_d_rdata unchanged after the write ack.
- F and D both held continuously for 4 accesses -> grants alternate F, D, F, D; acks at cycles 3, 7, 11, 15.
- L, F and D asserted together at cycle 0 -> L acked at cycle 3, F at 7, D at 11; the pointer is not moved by the L grant.
- i_reset asserted in WAIT during an F read -> no o_f_ack; o_busy = 0 the next cycle; the held F request is acked 4 cycles after reset is released.
- With MEM_ARB_RANGE_CHECK_EN and MEM_AW = 12, D read of 0x4000 -> o_mem_en stays 0; o_d_ack = 1 with o_d_err = 1 and o_d_rdata = 0xDEADBEEF. Without the macro, the same read accesses word 0.
